// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor: diff = a - b (mod 2^WIDTH).
// One bit is processed per clock, LSB first, through a single
// full-subtractor cell with a registered borrow. The complete per-bit
// borrow chain is exposed alongside the final borrow.
//
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the registered
// signed-overflow output `ovf`.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   in_valid   in   operands a/b presented
//   in_ready   out  block can accept operands (IDLE only)
//   a          in   [WIDTH] minuend
//   b          in   [WIDTH] subtrahend
//   out_valid  out  result registers hold a completed result (DONE only)
//   out_ready  in   downstream consumes result
//   diff       out  [WIDTH] a - b modulo 2^WIDTH
//   borrow     out  [WIDTH] borrow[i] = borrow out of bit i
//   borrow_out out  borrow[WIDTH-1]; set when a < b (unsigned)
//   ovf        out  signed overflow (only with SERIAL_SUBTRACTOR_OVF_EN)
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH-1:0] borrow_q, borrow_d;

  // Full-subtractor cell working on the current LSB of the shift registers.
  logic bit_a, bit_b, d_bit, bout;
  logic shifting, last_shift;

  assign bit_a      = a_sh_q[0];
  assign bit_b      = b_sh_q[0];
  assign d_bit      = bit_a ^ bit_b ^ bin_q;
  assign bout       = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bin_q);
  assign shifting   = (state_q == S_SHIFT);
  assign last_shift = shifting && (cnt_q == LAST_BIT);

  // Next state and datapath.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        bin_d  = bout;
        // Result bits enter at the MSB so that after WIDTH shifts bit 0
        // has travelled down to diff[0].
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_shift) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Per-bit borrow capture: bit gi is written only on the shift edge whose
  // counter equals gi, so earlier results stay visible until overwritten.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_borrow
    assign borrow_d[gi] = (shifting && (cnt_q == CNT_W'(gi))) ? bout : borrow_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Signed overflow is the XOR of the borrows out of the top two bits. On
  // the last shift edge borrow_q[WIDTH-2] is already final and bout is the
  // top borrow, so the flag is settled together with the rest of the result.
  logic ovf_q, ovf_d;

  assign ovf_d = last_shift ? (bout ^ borrow_q[WIDTH-2]) : ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  // Outputs are decoded straight from registers only.
  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow     = borrow_q;
  assign borrow_out = borrow_q[WIDTH-1];

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed bench for serial_subtractor. A WIDTH=4 instance is driven through
// normal operation, back-pressure, reset mid-operation and random operands;
// its expected results go into a queue at drive time and are popped by a
// monitor at each output handshake. A WIDTH=8 instance covers the
// busy-ignore case. Build with SERIAL_SUBTRACTOR_OVF_EN to also check ovf.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  typedef struct {
    logic [3:0] diff;
    logic [3:0] borrow;
    logic       bo;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // WIDTH=4 instance signals
  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       out_valid4;
  logic       out_ready4 = 1'b1;
  logic [3:0] diff4;
  logic [3:0] borrow4;
  logic       borrow_out4;

  // WIDTH=8 instance signals
  logic       in_valid8 = 1'b0;
  logic       in_ready8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       out_valid8;
  logic       out_ready8 = 1'b1;
  logic [7:0] diff8;
  logic [7:0] borrow8;
  logic       borrow_out8;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic       ovf4;
  logic       ovf8;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   results8 = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid4),
    .in_ready   (in_ready4),
    .a          (a4),
    .b          (b4),
    .out_valid  (out_valid4),
    .out_ready  (out_ready4),
    .diff       (diff4),
    .borrow     (borrow4),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf        (ovf4),
`endif
    .borrow_out (borrow_out4)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid8),
    .in_ready   (in_ready8),
    .a          (a8),
    .b          (b8),
    .out_valid  (out_valid8),
    .out_ready  (out_ready8),
    .diff       (diff8),
    .borrow     (borrow8),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf        (ovf8),
`endif
    .borrow_out (borrow_out8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference built from unsigned comparisons of the low i+1 bits, which is
  // exactly what "borrow out of bit i" means.
  function automatic exp_t model(input logic [3:0] x, input logic [3:0] y);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      int mask;
      mask = (1 << (i + 1)) - 1;
      e.borrow[i] = ((int'(x) & mask) < (int'(y) & mask));
    end
    e.diff = x - y;
    e.bo   = (x < y);
    e.ovf  = (x[3] != y[3]) && (e.diff[3] != x[3]);
    return e;
  endfunction

  function automatic exp_t mk(input logic [3:0] d, input logic [3:0] bw, input logic bo, input logic ov);
    exp_t e;
    e.diff = d; e.borrow = bw; e.bo = bo; e.ovf = ov;
    return e;
  endfunction

  // Present one operand pair to the 4-bit DUT, record its expected result
  // and measure the accept-to-out_valid latency.
  task automatic op4(input logic [3:0] x, input logic [3:0] y, input exp_t e);
    int n;
    check("in_ready_before_accept", 32'(in_ready4), 32'd1);
    a4 = x; b4 = y; in_valid4 = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'd4);
    $display("op4 a=%0d b=%0d expect diff=0x%0h borrow=%b bo=%0d latency=%0d",
             x, y, e.diff, e.borrow, e.bo, n);
  endtask

  // Scoreboard side: compare at each 4-bit output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready4) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", 32'(diff4), 32'(e.diff));
        check("borrow", 32'(borrow4), 32'(e.borrow));
        check("borrow_out", 32'(borrow_out4), 32'(e.bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("ovf", 32'(ovf4), 32'(e.ovf));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) results8++;
  end

  initial begin
    int n;
    // ---- reset ----
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready4), 32'd1);
    check("rst_out_valid", 32'(out_valid4), 32'd0);
    check("rst_diff", 32'(diff4), 32'd0);
    check("rst_borrow", 32'(borrow4), 32'd0);
    check("rst_borrow_out", 32'(borrow_out4), 32'd0);
    check("rst_in_ready8", 32'(in_ready8), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // ---- basic operations ----
    out_ready4 = 1'b1;
    op4(4'd9, 4'd3, mk(4'd6, 4'b0110, 1'b0, 1'b1));
    @(posedge clk); #1;
    check("after_hs_out_valid", 32'(out_valid4), 32'd0);
    check("after_hs_in_ready", 32'(in_ready4), 32'd1);
    op4(4'd3, 4'd9, mk(4'hA, 4'b1000, 1'b1, 1'b1));
    @(posedge clk); #1;

    // ---- back-pressure ----
    out_ready4 = 1'b0;
    op4(4'd5, 4'd5, mk(4'd0, 4'b0000, 1'b0, 1'b0));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid4), 32'd1);
      check("bp_diff", 32'(diff4), 32'd0);
      check("bp_in_ready", 32'(in_ready4), 32'd0);
    end
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 32'(out_valid4), 32'd0);
    check("bp_release_in_ready", 32'(in_ready4), 32'd1);

    // ---- reset in the middle of SHIFT ----
    a4 = 4'd7; b4 = 4'd2; in_valid4 = 1'b1;
    @(posedge clk); #1;          // accept edge
    in_valid4 = 1'b0;
    @(posedge clk); #1;          // first shift edge
    rst = 1'b1;
    @(posedge clk); #1;          // reset lands on the second shift edge
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready4), 32'd1);
    check("midrst_out_valid", 32'(out_valid4), 32'd0);
    check("midrst_diff", 32'(diff4), 32'd0);
    check("midrst_borrow", 32'(borrow4), 32'd0);
    $display("mid-op reset applied, in-flight 7-2 discarded");
    op4(4'd7, 4'd2, mk(4'd5, 4'b0000, 1'b0, 1'b0));
    @(posedge clk); #1;

    // ---- boundaries and overflow cases ----
    op4(4'd0, 4'd1, mk(4'hF, 4'b1111, 1'b1, 1'b0));
    @(posedge clk); #1;
    op4(4'h8, 4'h1, mk(4'h7, 4'b0111, 1'b0, 1'b1));
    @(posedge clk); #1;
    op4(4'h6, 4'h2, mk(4'h4, 4'b0000, 1'b0, 1'b0));
    @(posedge clk); #1;

    // ---- random operands ----
    for (int i = 0; i < 8; i++) begin
      logic [3:0] x, y;
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      op4(x, y, model(x, y));
      @(posedge clk); #1;
    end

    // ---- busy ignore on the 8-bit instance ----
    a8 = 8'h00; b8 = 8'h01; in_valid8 = 1'b1;
    @(posedge clk); #1;          // accept edge
    a8 = 8'h55;
    for (int i = 0; i < 8; i++) begin
      in_valid8 = ~in_valid8;
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("w8_out_valid", 32'(out_valid8), 32'd1);
    check("w8_diff", 32'(diff8), 32'hFF);
    check("w8_borrow", 32'(borrow8), 32'hFF);
    check("w8_borrow_out", 32'(borrow_out8), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check("w8_result_count", 32'(results8), 32'd1);
    $display("w8 a=0x00 b=0x01 diff=0x%0h borrow_out=%0d results=%0d",
             diff8, borrow_out8, results8);

    // ---- drain ----
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
